c2_bcd_seq_converter: RTL

Sequential, parametrised two's-complement-to-BCD converter using iterative double dabble, one input bit per clock.
- Converts a signed or unsigned binary value into N_DIGITS packed BCD digits plus a sign flag, with a start/done handshake.
- Sits between the keypad frequency-select datapath and the display/readback logic, which need decimal digits of signed frequency offsets.
- Trades latency for area: one shared add-3/shift stage instead of IN_WIDTH unrolled stages.

---
 rtl/c2_bcd_seq_converter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/c2_bcd_seq_converter.sv
// c2_bcd_seq_converter
// Sequential two's-complement (or unsigned) to packed BCD converter using
// iterative double dabble: one input bit is consumed per clock through a
// single shared add-3/shift stage.
// Optional feature macro: C2_BCD_OVERFLOW_FLAG_EN adds an 'ovf' output that
// reports magnitudes that do not fit in N_DIGITS decimal digits.
module c2_bcd_seq_converter #(
   parameter int IN_WIDTH = 24,
   parameter int N_DIGITS = 7,
   parameter int SIGNED   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_WIDTH-1:0]   data_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*N_DIGITS-1:0] bcd_out,
`ifdef C2_BCD_OVERFLOW_FLAG_EN
   output logic                  ovf,
`endif
   output logic                  sign_out
);

`ifdef C2_BCD_OVERFLOW_FLAG_EN
   // one hidden carry digit above the visible ones catches overflow
   localparam int ACC_DIGITS = N_DIGITS + 1;
`else
   localparam int ACC_DIGITS = N_DIGITS;
`endif
   localparam int ACC_W     = 4 * ACC_DIGITS;
   localparam int CNT_W     = $clog2(IN_WIDTH + 1);
   localparam bit IS_SIGNED = (SIGNED != 0);
   localparam logic [IN_WIDTH-1:0] ONE = {{(IN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_FINISH
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [IN_WIDTH-1:0] mag_q;
   logic [ACC_W-1:0]    acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                sign_q;
   logic [IN_WIDTH-1:0] mag_in;
   logic                sign_in;
   logic [ACC_W-1:0]    acc_adj;
   logic [ACC_W-1:0]    acc_shift;
`ifdef C2_BCD_OVERFLOW_FLAG_EN
   logic                sticky_q;
`endif

   // Sign and magnitude of the incoming word; the most-negative value maps
   // to 2^(IN_WIDTH-1), which still fits as an IN_WIDTH-bit unsigned number.
   always_comb begin
      sign_in = IS_SIGNED && data_in[IN_WIDTH-1];
      mag_in  = sign_in ? (~data_in + ONE) : data_in;
   end

   // Add-3 correction on every digit in parallel, then the combined shift
   // that pulls the next magnitude bit into the units digit.
   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < ACC_DIGITS; k++) begin
         if (acc_q[4*k +: 4] > 4'd4) begin
            acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
         end
      end
      acc_shift = {acc_adj[ACC_W-2:0], mag_q[IN_WIDTH-1]};
   end

   // Next-state logic: IDLE waits for start, CONV runs IN_WIDTH steps,
   // FINISH publishes the result for one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_CONV;
         S_CONV:   if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered outputs; results only change in FINISH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd_out  <= '0;
         sign_out <= 1'b0;
`ifdef C2_BCD_OVERFLOW_FLAG_EN
         sticky_q <= 1'b0;
         ovf      <= 1'b0;
`endif
      end else begin
         busy <= (state_d != S_IDLE);
         done <= (state_q == S_FINISH);
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  mag_q  <= mag_in;
                  sign_q <= sign_in && (mag_in != '0);
                  acc_q  <= '0;
                  cnt_q  <= CNT_W'(IN_WIDTH);
`ifdef C2_BCD_OVERFLOW_FLAG_EN
                  sticky_q <= 1'b0;
`endif
               end
            end
            S_CONV: begin
               acc_q <= acc_shift;
               mag_q <= {mag_q[IN_WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - CNT_W'(1);
`ifdef C2_BCD_OVERFLOW_FLAG_EN
               if (acc_adj[ACC_W-1]) sticky_q <= 1'b1;
`endif
            end
            S_FINISH: begin
               bcd_out  <= acc_q[4*N_DIGITS-1:0];
               sign_out <= sign_q;
`ifdef C2_BCD_OVERFLOW_FLAG_EN
               ovf <= sticky_q || (acc_q[ACC_W-1 -: 4] != 4'd0);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
